// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encoding and the datapath width shared with the ALU.
package mul_div_unit_pkg;

    localparam int MDU_DATA_WIDTH = 32;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore result signs.
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] result
);

    // Negate when requested, pass through otherwise
    always_comb begin
        result = value;
        if (neg) begin
            result = (~value) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. One product/quotient bit per
// CALC cycle, sign correction in FIX, MTHI/MTLO accepted only while not busy.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = MDU_DATA_WIDTH,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  hi_we,
    input  logic                  lo_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

    mdu_state_e           state_r, next_state_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic                 busy_r, done_r;
    logic [W-1:0]         hi_r, lo_r;
    logic                 is_div_r, neg_res_r, neg_rem_r, div_zero_r;
    logic [W-1:0]         operand_r;
    logic [2*W-1:0]       prod_r;
    logic [W-1:0]         rem_r;

    logic                 launch_s, is_div_s, signed_s;
    logic [W-1:0]         a_mag_s, b_mag_s;
    logic [W:0]           add_s, shift_s;
    logic [2*W-1:0]       mul_next_s, prod_fix_s;
    logic [W-1:0]         rem_next_s, quo_next_s, quo_fix_s, rem_fix_s;

    assign is_div_s = (op == MDU_DIV) || (op == MDU_DIVU);
    assign signed_s = (op == MDU_MULT) || (op == MDU_DIV);

    mdu_sign_fix #(.WIDTH(W)) u_abs_a (.neg(signed_s & A[W-1]), .value(A), .result(a_mag_s));
    mdu_sign_fix #(.WIDTH(W)) u_abs_b (.neg(signed_s & B[W-1]), .value(B), .result(b_mag_s));
    mdu_sign_fix #(.WIDTH(2*W)) u_fix_prod (.neg(neg_res_r), .value(prod_r), .result(prod_fix_s));
    mdu_sign_fix #(.WIDTH(W)) u_fix_quo (.neg(neg_res_r), .value(prod_r[W-1:0]), .result(quo_fix_s));
    mdu_sign_fix #(.WIDTH(W)) u_fix_rem (.neg(neg_rem_r), .value(rem_r), .result(rem_fix_s));

    // Next-state decode; start is honoured only in IDLE or DONE
    always_comb begin
        next_state_s = state_r;
        launch_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = CALC;
                    launch_s     = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == LAST_CNT) begin
                    next_state_s = FIX;
                end else begin
                    next_state_s = CALC;
                end
            end
            FIX: next_state_s = DONE;
            DONE: begin
                if (start) begin
                    next_state_s = CALC;
                    launch_s     = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // One shift-add step and one restoring-division step per cycle
    always_comb begin
        add_s      = {1'b0, prod_r[2*W-1:W]};
        mul_next_s = prod_r;
        shift_s    = {rem_r, prod_r[W-1]};
        rem_next_s = rem_r;
        quo_next_s = prod_r[W-1:0];
        if (prod_r[0]) begin
            add_s = {1'b0, prod_r[2*W-1:W]} + {1'b0, operand_r};
        end else begin
            add_s = {1'b0, prod_r[2*W-1:W]};
        end
        mul_next_s = {add_s, prod_r[W-1:1]};
        // The shifted remainder is below 2*divisor, so the difference fits W bits
        if (shift_s >= {1'b0, operand_r}) begin
            rem_next_s = W'(shift_s - {1'b0, operand_r});
            quo_next_s = {prod_r[W-2:0], 1'b1};
        end else begin
            rem_next_s = shift_s[W-1:0];
            quo_next_s = {prod_r[W-2:0], 1'b0};
        end
    end

    // State register with registered busy/done flags
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == CALC) || (next_state_s == FIX);
            done_r  <= (next_state_s == DONE);
        end
    end

    // Operand latch and iteration datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r      <= {CNT_WIDTH{1'b0}};
            is_div_r   <= 1'b0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
            operand_r  <= {W{1'b0}};
            prod_r     <= {(2*W){1'b0}};
            rem_r      <= {W{1'b0}};
        end else if (launch_s) begin
            cnt_r      <= {CNT_WIDTH{1'b0}};
            is_div_r   <= is_div_s;
            neg_res_r  <= signed_s & (A[W-1] ^ B[W-1]);
            neg_rem_r  <= signed_s & is_div_s & A[W-1];
            div_zero_r <= is_div_s && (B == {W{1'b0}});
            operand_r  <= is_div_s ? b_mag_s : a_mag_s;
            prod_r     <= {{W{1'b0}}, (is_div_s ? a_mag_s : b_mag_s)};
            rem_r      <= {W{1'b0}};
        end else if (state_r == CALC) begin
            cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (is_div_r) begin
                prod_r <= {prod_r[2*W-1:W], quo_next_s};
                rem_r  <= rem_next_s;
            end else begin
                prod_r <= mul_next_s;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // HI/LO: result write in FIX, otherwise MTHI/MTLO when not busy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_r <= {W{1'b0}};
            lo_r <= {W{1'b0}};
        end else if (state_r == FIX) begin
            if (is_div_r) begin
                hi_r <= rem_fix_s;
                lo_r <= div_zero_r ? {W{1'b1}} : quo_fix_s;
            end else begin
                {hi_r, lo_r} <= prod_fix_s;
            end
        end else if (!busy_r) begin
            if (hi_we) begin
                hi_r <= wdata;
            end
            if (lo_we) begin
                lo_r <= wdata;
            end
        end else begin
            hi_r <= hi_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases, randomized ops against an
// arithmetic reference model, MTHI/MTLO, mid-operation reset and back-to-back starts.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] A = 32'd0, B = 32'd0, wdata = 32'd0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .A(A), .B(B),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    // Reference: {hi, lo} computed with plain integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: r = 64'(sa * sb);
            2'b01: r = {32'd0, a} * {32'd0, b};
            2'b10: if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                   else r = {32'(sa % sb), 32'(sa / sb)};
            default: if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                     else r = {a % b, a / b};
        endcase
        return r;
    endfunction

    // Launch one op and wait for completion; returns observations only
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] h, output logic [31:0] l, output int cyc,
                          output logic d_end, output logic d_next);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        d_end = done; h = hi; l = lo;
        @(negedge clk);
        d_next = done;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got=%h exp=0", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got=%h exp=0", lo); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [6] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10};
        logic [31:0] t_a  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h1234, 32'h80000000};
        logic [31:0] t_b  [6] = '{32'hFFFFFFFF, 32'd5, 32'd2, 32'd7, 32'd0, 32'hFFFFFFFF};
        logic [31:0] t_hi [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'h1234, 32'd0};
        logic [31:0] t_lo [6] = '{32'h00000001, 32'hFFFFFFF1, 32'hFFFFFFFD, 32'd14, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] h, l;
        int cyc;
        logic de, dn;
        for (int i = 0; i < 6; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], h, l, cyc, de, dn);
            n_cmp++; if (cyc !== 33) begin n_fail++; $display("FAIL dir%0d_busy_cycles got=%0d exp=33", i, cyc); end
            n_cmp++; if (de !== 1'b1) begin n_fail++; $display("FAIL dir%0d_done got=%b exp=1", i, de); end
            n_cmp++; if (dn !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, dn); end
            n_cmp++; if (h !== t_hi[i]) begin n_fail++; $display("FAIL dir%0d_hi got=%h exp=%h", i, h, t_hi[i]); end
            n_cmp++; if (l !== t_lo[i]) begin n_fail++; $display("FAIL dir%0d_lo got=%h exp=%h", i, l, t_lo[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] specials [4] = '{32'd0, 32'd1, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] a, b, h, l;
        logic [1:0]  o;
        logic [63:0] exp;
        int cyc;
        logic de, dn;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            exp = model(o, a, b);
            run_op(o, a, b, h, l, cyc, de, dn);
            n_cmp++; if (cyc !== 33 || de !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_timing cyc=%0d done=%b exp 33/1", i, cyc, de); end
            n_cmp++; if ({h, l} !== exp) begin n_fail++; $display("FAIL rnd%0d op=%0d a=%h b=%h got=%h_%h exp=%h", i, o, a, b, h, l, exp); end
        end
    endtask

    task automatic test_mthi_mtlo();
        int n;
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'hAAAA5555;
        @(negedge clk);
        hi_we = 1'b0;
        n_cmp++; if (hi !== 32'hAAAA5555) begin n_fail++; $display("FAIL mthi got=%h exp=aaaa5555", hi); end
        lo_we = 1'b1; wdata = 32'h5555AAAA;
        @(negedge clk);
        lo_we = 1'b0;
        n_cmp++; if (lo !== 32'h5555AAAA || hi !== 32'hAAAA5555) begin n_fail++; $display("FAIL mtlo got=%h_%h exp=aaaa5555_5555aaaa", hi, lo); end
        // Start and MTHI at the same edge: write lands now, FIX overwrites later
        start = 1'b1; op = 2'b01; A = 32'd3; B = 32'd4; hi_we = 1'b1; wdata = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        n_cmp++; if (hi !== 32'hDEADBEEF) begin n_fail++; $display("FAIL start_mthi got=%h exp=deadbeef", hi); end
        n = 0;
        while (busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
        n_cmp++; if (hi !== 32'd0 || lo !== 32'd12) begin n_fail++; $display("FAIL start_mthi_result got=%h_%h exp=0_c", hi, lo); end
        // Writes while busy are dropped
        start = 1'b1; op = 2'b01; A = 32'd5; B = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        lo_we = 1'b1; hi_we = 1'b1; wdata = 32'h0BADF00D;
        @(negedge clk);
        lo_we = 1'b0; hi_we = 1'b0;
        n_cmp++; if (lo !== 32'd12 || hi !== 32'd0) begin n_fail++; $display("FAIL mtlo_busy got=%h_%h exp=0_c", hi, lo); end
        n = 0;
        while (busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
        n_cmp++; if (lo !== 32'd30 || hi !== 32'd0) begin n_fail++; $display("FAIL mtlo_busy_result got=%h_%h exp=0_1e", hi, lo); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h11112222;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        start = 1'b1; op = 2'b01; A = 32'hFFFFFFFF; B = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        resetn = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags got=%b%b exp=00", busy, done); end
        n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", hi, lo); end
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0) begin n_fail++; $display("FAIL rstmid_idle got=%b%b %h exp=00 0", busy, done, hi); end
    endtask

    task automatic test_back_to_back();
        int n, pulses;
        logic [63:0] exp1, exp2;
        exp1 = model(2'b00, 32'hFFFF0003, 32'h00007001);
        exp2 = model(2'b10, 32'h80000001, 32'd3);
        @(negedge clk);
        start = 1'b1; op = 2'b00; A = 32'hFFFF0003; B = 32'h00007001;
        @(negedge clk);
        // Held start with new operands: ignored while busy, taken in DONE
        op = 2'b10; A = 32'h80000001; B = 32'd3;
        n = 0;
        while (busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
        n_cmp++; if (done !== 1'b1 || {hi, lo} !== exp1) begin n_fail++; $display("FAIL b2b_first done=%b got=%h_%h exp=%h", done, hi, lo, exp1); end
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_no_gap busy=%b done=%b exp 1/0", busy, done); end
        n = 0; pulses = 0;
        while (busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
        n_cmp++; if (n !== 33) begin n_fail++; $display("FAIL b2b_second_cycles got=%0d exp=33", n); end
        n_cmp++; if ({hi, lo} !== exp2) begin n_fail++; $display("FAIL b2b_second got=%h_%h exp=%h", hi, lo, exp2); end
        for (int i = 0; i < 3; i++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL b2b_done_pulse got=%0d exp=1", pulses); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
